// File: rtl/instr_decoder.sv
// rtl/instr_decoder.sv - front-end decode stage for the 9-bit CPU
//
// Purpose: accepts 9-bit instruction words over a valid/ready handshake and
// registers them as a decoded bundle: opcode class, destination, operand
// field, variant bit and the assembled 8-bit literal. It also holds a
// RUN/HALT state and counts accepted instructions.
//
// Ports:
//   clk, reset           clock; asynchronous active-high reset
//   instr, instr_valid   instruction word from fetch ([8:4] opcode, [3:0] operand)
//   instr_ready          decoder accepts instr this cycle
//   resume               single-cycle pulse that leaves HALT
//   dec_valid, dec_ready registered bundle handshake towards execute
//   dec_cls/dst/src/sel  decoded fields
//   dec_lit8             literal register after this instruction
//   halted               decoder is in HALT
//   dec_count            instructions accepted since reset (wraps)

module instr_decoder #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [8:0]       instr,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic             resume,
    output logic             dec_valid,
    input  logic             dec_ready,
    output logic [3:0]       dec_cls,
    output logic [3:0]       dec_dst,
    output logic [3:0]       dec_src,
    output logic             dec_sel,
    output logic [7:0]       dec_lit8,
    output logic             halted,
    output logic [CNT_W-1:0] dec_count
);

    localparam logic [3:0] CLS_LIT     = 4'd0;
    localparam logic [3:0] CLS_MOV     = 4'd1;
    localparam logic [3:0] CLS_JTSR    = 4'd2;
    localparam logic [3:0] CLS_LOAD    = 4'd3;
    localparam logic [3:0] CLS_STOR    = 4'd4;
    localparam logic [3:0] CLS_INCDEC  = 4'd5;
    localparam logic [3:0] CLS_JUMP    = 4'd6;
    localparam logic [3:0] CLS_BRANCH  = 4'd7;
    localparam logic [3:0] CLS_SETH    = 4'd8;
    localparam logic [3:0] CLS_MATH    = 4'd9;
    localparam logic [3:0] CLS_SHIFT   = 4'd10;
    localparam logic [3:0] CLS_FLIP    = 4'd11;
    localparam logic [3:0] CLS_FUNC    = 4'd12;
    localparam logic [3:0] CLS_HALT    = 4'd13;
    localparam logic [3:0] CLS_ILLEGAL = 4'd15;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t           state_q,     state_d;
    logic             dec_valid_q, dec_valid_d;
    logic [3:0]       cls_q,       cls_d;
    logic [3:0]       dst_q,       dst_d;
    logic [3:0]       src_q,       src_d;
    logic             sel_q,       sel_d;
    logic [7:0]       lit8_q,      lit8_d;
    logic [CNT_W-1:0] count_q,     count_d;

    logic [4:0] opcode;
    logic [3:0] operand;
    logic [3:0] dcd_cls;
    logic [3:0] dcd_dst;
    logic       accept;

    assign opcode  = instr[8:4];
    assign operand = instr[3:0];

    // Pure combinational decode of the presented word.
    always_comb begin
        dcd_cls = CLS_ILLEGAL;
        dcd_dst = 4'd0;
        case (opcode) inside
            5'b00000, 5'b00001: dcd_cls = CLS_LIT;
            [5'b00010:5'b01110]: begin
                dcd_cls = CLS_MOV;
                dcd_dst = opcode[3:0];
            end
            5'b01111:           dcd_cls = CLS_JTSR;
            5'b10000:           dcd_cls = CLS_LOAD;
            5'b10001:           dcd_cls = CLS_STOR;
            5'b10010, 5'b10011: dcd_cls = CLS_INCDEC;
            5'b10100, 5'b10101: dcd_cls = CLS_JUMP;
            5'b10110, 5'b10111: dcd_cls = CLS_BRANCH;
            5'b11001:           dcd_cls = CLS_SETH;
            5'b11010, 5'b11011: begin
                dcd_cls = CLS_MATH;
                dcd_dst = {3'b000, opcode[0]};   // r or s
            end
            5'b11100, 5'b11101: dcd_cls = CLS_SHIFT;
            5'b11110:           dcd_cls = CLS_FLIP;
            5'b11111:           dcd_cls = (operand == 4'hF) ? CLS_HALT : CLS_FUNC;
            default:            dcd_cls = CLS_ILLEGAL;
        endcase
    end

    // The output slot is free when empty or being drained this cycle.
    assign instr_ready = (state_q == ST_RUN) && (!dec_valid_q || dec_ready);
    assign accept      = instr_valid && instr_ready;

    always_comb begin
        state_d     = state_q;
        dec_valid_d = dec_valid_q;
        cls_d       = cls_q;
        dst_d       = dst_q;
        src_d       = src_q;
        sel_d       = sel_q;
        lit8_d      = lit8_q;
        count_d     = count_q;

        if (accept) begin
            dec_valid_d = 1'b1;
            cls_d       = dcd_cls;
            dst_d       = dcd_dst;
            src_d       = operand;
            sel_d       = opcode[0];
            count_d     = count_q + CNT_W'(1);
            if (opcode == 5'b00000) begin
                lit8_d = {lit8_q[7:4], operand};
            end else if (opcode == 5'b00001) begin
                lit8_d = {operand, lit8_q[3:0]};
            end
        end else if (dec_ready) begin
            dec_valid_d = 1'b0;
        end

        // Accept only happens in RUN, so a resume coinciding with a HALT
        // accept is naturally ignored.
        if (accept && (dcd_cls == CLS_HALT)) begin
            state_d = ST_HALT;
        end else if ((state_q == ST_HALT) && resume) begin
            state_d = ST_RUN;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_RUN;
            dec_valid_q <= 1'b0;
            cls_q       <= 4'd0;
            dst_q       <= 4'd0;
            src_q       <= 4'd0;
            sel_q       <= 1'b0;
            lit8_q      <= 8'd0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            dec_valid_q <= dec_valid_d;
            cls_q       <= cls_d;
            dst_q       <= dst_d;
            src_q       <= src_d;
            sel_q       <= sel_d;
            lit8_q      <= lit8_d;
            count_q     <= count_d;
        end
    end

    assign dec_valid = dec_valid_q;
    assign dec_cls   = cls_q;
    assign dec_dst   = dst_q;
    assign dec_src   = src_q;
    assign dec_sel   = sel_q;
    assign dec_lit8  = lit8_q;
    assign halted    = (state_q == ST_HALT);
    assign dec_count = count_q;

endmodule

// File: tb/tb_instr_decoder.sv
// tb/tb_instr_decoder.sv - self-checking bench for instr_decoder

module tb_instr_decoder;

    logic       clk;
    logic       reset;
    logic [8:0] instr;
    logic       instr_valid;
    logic       instr_ready;
    logic       resume;
    logic       dec_valid;
    logic       dec_ready;
    logic [3:0] dec_cls;
    logic [3:0] dec_dst;
    logic [3:0] dec_src;
    logic       dec_sel;
    logic [7:0] dec_lit8;
    logic       halted;
    logic [3:0] dec_count;

    instr_decoder #(.CNT_W(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .resume      (resume),
        .dec_valid   (dec_valid),
        .dec_ready   (dec_ready),
        .dec_cls     (dec_cls),
        .dec_dst     (dec_dst),
        .dec_src     (dec_src),
        .dec_sel     (dec_sel),
        .dec_lit8    (dec_lit8),
        .halted      (halted),
        .dec_count   (dec_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [8:0] w;
        logic [3:0] cls;
        logic [3:0] dst;
        logic [3:0] src;
        logic       sel;
        logic [7:0] lit;
        logic [3:0] cnt;
    } vec_t;

    vec_t       tbl [19];
    vec_t       sb [$];
    int         checks;
    int         errors;
    logic [3:0] acc_cnt;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Negedge sample point; also retires the bundle that execute takes at
    // the coming edge.
    task automatic tick();
        vec_t e;
        @(negedge clk);
        if (!reset && dec_valid && dec_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL bundle_unexpected got cls=%0d src=%h", dec_cls, dec_src);
            end else begin
                e = sb.pop_front();
                if (dec_cls !== e.cls || dec_dst !== e.dst || dec_src !== e.src ||
                    dec_sel !== e.sel || dec_lit8 !== e.lit || dec_count !== e.cnt) begin
                    errors++;
                    $display("FAIL bundle instr=%h got cls=%0d dst=%0d src=%h sel=%0d lit=%h cnt=%0d want cls=%0d dst=%0d src=%h sel=%0d lit=%h cnt=%0d",
                             e.w, dec_cls, dec_dst, dec_src, dec_sel, dec_lit8, dec_count,
                             e.cls, e.dst, e.src, e.sel, e.lit, e.cnt);
                end
            end
        end
    endtask

    // Call at posedge+1. Returns at posedge+1 after the accepting edge.
    task automatic send(input vec_t e, output int waited);
        instr       = e.w;
        instr_valid = 1'b1;
        waited      = 0;
        forever begin
            tick();
            if (instr_ready) break;
            waited++;
            if (waited > 50) break;
        end
        if (waited > 50) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout instr=%h got no accept want accept", e.w);
        end else begin
            acc_cnt = acc_cnt + 4'd1;
            e.cnt   = acc_cnt;
            sb.push_back(e);
        end
        step();
        instr_valid = 1'b0;
    endtask

    task automatic drain();
        repeat (3) begin
            tick();
            step();
        end
    endtask

    function automatic vec_t mk(input logic [8:0] w, input logic [3:0] cls, input logic [3:0] dst,
                                input logic [3:0] src, input logic sel, input logic [7:0] lit);
        vec_t v;
        v.w = w; v.cls = cls; v.dst = dst; v.src = src; v.sel = sel; v.lit = lit; v.cnt = 4'd0;
        return v;
    endfunction

    initial begin
        int   waited;
        int   bad;
        vec_t a;
        vec_t b;

        checks      = 0;
        errors      = 0;
        acc_cnt     = 4'd0;
        reset       = 1'b1;
        instr       = 9'd0;
        instr_valid = 1'b0;
        resume      = 1'b0;
        dec_ready   = 1'b1;

        tbl[0]  = mk(9'h005, 4'd0,  4'd0,  4'h5, 1'b0, 8'h05);
        tbl[1]  = mk(9'h01A, 4'd0,  4'd0,  4'hA, 1'b1, 8'hA5);
        tbl[2]  = mk(9'h026, 4'd1,  4'd2,  4'h6, 1'b0, 8'hA5);
        tbl[3]  = mk(9'h1B8, 4'd9,  4'd1,  4'h8, 1'b1, 8'hA5);
        tbl[4]  = mk(9'h180, 4'd15, 4'd0,  4'h0, 1'b0, 8'hA5);
        tbl[5]  = mk(9'h0F3, 4'd2,  4'd0,  4'h3, 1'b1, 8'hA5);
        tbl[6]  = mk(9'h103, 4'd3,  4'd0,  4'h3, 1'b0, 8'hA5);
        tbl[7]  = mk(9'h117, 4'd4,  4'd0,  4'h7, 1'b1, 8'hA5);
        tbl[8]  = mk(9'h134, 4'd5,  4'd0,  4'h4, 1'b1, 8'hA5);
        tbl[9]  = mk(9'h14C, 4'd6,  4'd0,  4'hC, 1'b0, 8'hA5);
        tbl[10] = mk(9'h179, 4'd7,  4'd0,  4'h9, 1'b1, 8'hA5);
        tbl[11] = mk(9'h192, 4'd8,  4'd0,  4'h2, 1'b1, 8'hA5);
        tbl[12] = mk(9'h1D1, 4'd10, 4'd0,  4'h1, 1'b1, 8'hA5);
        tbl[13] = mk(9'h1E0, 4'd11, 4'd0,  4'h0, 1'b0, 8'hA5);
        tbl[14] = mk(9'h1F3, 4'd12, 4'd0,  4'h3, 1'b1, 8'hA5);
        tbl[15] = mk(9'h0EF, 4'd1,  4'd14, 4'hF, 1'b0, 8'hA5);
        tbl[16] = mk(9'h0D0, 4'd1,  4'd13, 4'h0, 1'b1, 8'hA5);
        tbl[17] = mk(9'h003, 4'd0,  4'd0,  4'h3, 1'b0, 8'hA3);
        tbl[18] = mk(9'h1A5, 4'd9,  4'd0,  4'h5, 1'b0, 8'hA3);

        repeat (2) step();
        reset = 1'b0;
        tick();
        chk("rst_dec_valid",   32'(dec_valid),   32'd0);
        chk("rst_halted",      32'(halted),      32'd0);
        chk("rst_instr_ready", 32'(instr_ready), 32'd1);
        chk("rst_count",       32'(dec_count),   32'd0);
        chk("rst_lit8",        32'(dec_lit8),    32'd0);
        chk("rst_cls",         32'(dec_cls),     32'd0);
        step();

        // Streamed decode table; 19 accepts also wraps the 4-bit counter.
        for (int i = 0; i < 19; i++) begin
            send(tbl[i], waited);
            chk("stream_no_stall", 32'(waited), 32'd0);
        end
        drain();
        chk("count_after_table", 32'(dec_count), 32'd3);

        // Backpressure: outputs hold, ready low, then next word accepted at release.
        a = mk(9'h120, 4'd5, 4'd0, 4'h0, 1'b0, 8'hA3);
        b = mk(9'h135, 4'd5, 4'd0, 4'h5, 1'b1, 8'hA3);
        dec_ready = 1'b0;
        send(a, waited);
        instr       = b.w;
        instr_valid = 1'b1;
        bad = 0;
        repeat (3) begin
            tick();
            if (instr_ready !== 1'b0 || dec_valid !== 1'b1 || dec_src !== a.src || dec_cls !== a.cls) bad++;
            step();
        end
        chk("backpressure_hold", 32'(bad), 32'd0);
        dec_ready = 1'b1;
        send(b, waited);
        chk("release_no_gap", 32'(waited), 32'd0);
        drain();

        // HALT blocks the next word until resume.
        send(mk(9'h1FF, 4'd13, 4'd0, 4'hF, 1'b1, 8'hA3), waited);
        tick();
        chk("halted_set", 32'(halted), 32'd1);
        instr       = 9'h120;
        instr_valid = 1'b1;
        bad = 0;
        step();
        repeat (10) begin
            tick();
            if (instr_ready !== 1'b0) bad++;
            step();
        end
        chk("halt_blocks", 32'(bad), 32'd0);
        resume = 1'b1;
        tick();
        chk("ready_low_resume_cycle", 32'(instr_ready), 32'd0);
        step();
        resume = 1'b0;
        chk("halted_cleared", 32'(halted), 32'd0);
        send(a, waited);
        chk("resume_next_cycle", 32'(waited), 32'd0);
        drain();

        // resume coincident with HALT accept is ignored.
        resume = 1'b1;
        send(mk(9'h1FF, 4'd13, 4'd0, 4'hF, 1'b1, 8'hA3), waited);
        resume = 1'b0;
        tick();
        chk("resume_same_cycle_ignored", 32'(halted), 32'd1);
        step();
        resume = 1'b1;
        step();
        resume = 1'b0;
        tick();
        chk("resume_pulse", 32'(halted), 32'd0);
        step();
        drain();

        // Reset while halted with a stalled bundle.
        dec_ready = 1'b0;
        send(mk(9'h1FF, 4'd13, 4'd0, 4'hF, 1'b1, 8'hA3), waited);
        tick();
        chk("pre_reset_halted", 32'(halted),    32'd1);
        chk("pre_reset_valid",  32'(dec_valid), 32'd1);
        step();
        reset = 1'b1;
        tick();
        chk("mid_reset_valid", 32'(dec_valid),   32'd0);
        chk("mid_reset_halt",  32'(halted),      32'd0);
        chk("mid_reset_lit8",  32'(dec_lit8),    32'd0);
        chk("mid_reset_ready", 32'(instr_ready), 32'd1);
        chk("mid_reset_count", 32'(dec_count),   32'd0);
        sb.delete();
        acc_cnt = 4'd0;
        step();
        reset     = 1'b0;
        dec_ready = 1'b1;

        // 17 accepts on a 4-bit counter wrap to 1.
        for (int i = 0; i < 17; i++) begin
            send(mk(9'h120, 4'd5, 4'd0, 4'h0, 1'b0, 8'h00), waited);
        end
        drain();
        chk("count_wrap_17", 32'(dec_count), 32'd1);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
